// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    READ,
    RACK,
    WAIT_STOP
  } state_t;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h76;
  localparam logic [7:0] CHIP_ID_REG         = 8'hD0;
  localparam logic [7:0] UNIMPL_VALUE        = 8'hFF;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw SCL/SDA bus levels into the clk domain and derives
// SCL edges plus START/STOP conditions from the synchronised samples.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] and [1] form the synchroniser, [2] holds the previous synced value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift both lines through the synchroniser; the idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_responder_regfile.sv
// I2C target with a byte-addressed register file and auto-incrementing pointer.
// Build option: define CHIP_ID_EN to make register 0xD0 a read-only chip id.
module i2c_responder_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] CHIP_ID     = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_out,
  output logic       sda_in,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int         IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);

  state_t     state_q, state_d;
  logic [3:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] pointer;
  logic [7:0] mem [REG_COUNT];

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic sda_d, busy_d;
  logic bit_clr, bit_inc, ack_seen;
  logic shift_in, shift_out, load_tx;
  logic ptr_load, ptr_inc, wr_fire;
  logic ptr_store;
  logic addr_match, rw_bit;
  logic [7:0] byte_now, rd_val;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda_out),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign addr_match = (shift_q[7:1] == TARGET_ADDR);
  assign rw_bit     = shift_q[0];
  assign byte_now   = {shift_q[6:0], sda_s};

  // Value presented for the current pointer and whether a write there is kept.
  always_comb begin
    ptr_store = ({1'b0, pointer} < REG_LIMIT);
    rd_val    = ptr_store ? mem[pointer[IDX_W-1:0]] : UNIMPL_VALUE;
`ifdef CHIP_ID_EN
    if (pointer == CHIP_ID_REG) begin
      rd_val    = CHIP_ID;
      ptr_store = 1'b0;
    end
`endif
  end

  // Protocol state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: bus conditions win, otherwise advance on SCL edges.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:      if (scl_fall && bit_cnt == 4'd8) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall) state_d = rw_bit ? READ : REG;
        REG:       if (scl_fall && bit_cnt == 4'd8) state_d = REG_ACK;
        REG_ACK:   if (scl_fall) state_d = WDATA;
        WDATA:     if (scl_fall && bit_cnt == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        READ:      if (scl_fall && bit_cnt == 4'd8) state_d = RACK;
        RACK: begin
          if (scl_rise && sda_s)                  state_d = WAIT_STOP;
          else if (scl_fall && bit_cnt == 4'd9)   state_d = READ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Per-cycle actions: SDA drive, busy, shifting, pointer and write pulses.
  always_comb begin
    sda_d     = sda_in;
    busy_d    = busy;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    ack_seen  = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    load_tx   = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    wr_fire   = 1'b0;
    if (stop_det) begin
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      bit_clr = 1'b1;
    end else if (start_det) begin
      sda_d   = 1'b1;
      bit_clr = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (bit_cnt < 4'd8) begin
            shift_in = 1'b1;
            bit_inc  = 1'b1;
            wr_fire  = (state_q == WDATA) && (bit_cnt == 4'd7);
          end
        end
        READ: if (bit_cnt < 4'd8) bit_inc = 1'b1;
        RACK: begin
          if (sda_s) busy_d   = 1'b0;
          else       ack_seen = 1'b1;
        end
        default: ;
      endcase
      if (wr_fire) ptr_inc = 1'b1;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: begin
          if (bit_cnt == 4'd8) begin
            if (addr_match) begin
              sda_d  = 1'b0;
              busy_d = 1'b1;
            end else begin
              busy_d = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          bit_clr = 1'b1;
          if (rw_bit) begin
            load_tx = 1'b1;
            sda_d   = rd_val[7];
          end else begin
            sda_d   = 1'b1;
          end
        end
        REG: begin
          if (bit_cnt == 4'd8) begin
            sda_d    = 1'b0;
            ptr_load = 1'b1;
          end
        end
        WDATA: if (bit_cnt == 4'd8) sda_d = 1'b0;
        REG_ACK, WDATA_ACK: begin
          sda_d   = 1'b1;
          bit_clr = 1'b1;
        end
        READ: begin
          if (bit_cnt == 4'd8) begin
            sda_d   = 1'b1;
            ptr_inc = 1'b1;
          end else begin
            sda_d     = shift_q[7];
            shift_out = 1'b1;
          end
        end
        RACK: begin
          if (bit_cnt == 4'd9) begin
            bit_clr = 1'b1;
            load_tx = 1'b1;
            sda_d   = rd_val[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers following the decoded actions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_in    <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= 4'd0;
      shift_q   <= 8'h00;
      pointer   <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      sda_in    <= sda_d;
      busy      <= busy_d;
      wr_strobe <= wr_fire;
      if (bit_clr)       bit_cnt <= 4'd0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 4'd1;
      else if (ack_seen) bit_cnt <= 4'd9;
      if (shift_in)       shift_q <= byte_now;
      else if (load_tx)   shift_q <= {rd_val[6:0], 1'b1};
      else if (shift_out) shift_q <= {shift_q[6:0], 1'b1};
      if (ptr_load)     pointer <= shift_q;
      else if (ptr_inc) pointer <= pointer + 8'd1;
      if (wr_fire) begin
        wr_addr <= pointer;
        wr_data <= byte_now;
      end
    end
  end

  // Register file storage; bytes outside the implemented range are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= 8'h00;
    end else if (wr_fire && ptr_store) begin
      mem[pointer[IDX_W-1:0]] <= byte_now;
    end
  end

endmodule

// File: tb/tb_i2c_responder_regfile.sv
// Self-checking bench: bit-banged I2C master, transaction-level register model
// and a per-cycle write-strobe scoreboard.
module tb_i2c_responder_regfile;

  localparam int         Q      = 5;
  localparam logic [6:0] TARGET = 7'h76;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_in;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  model_mem [16];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q [$];
  logic [7:0]  data_q [$];
  logic [7:0]  rx_q [$];

  assign sda_bus = sda_m & sda_in;

  i2c_responder_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_m),
    .sda_out   (sda_bus),
    .sda_in    (sda_in),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Records one comparison and reports it when it misses.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // What the register map must return for a byte address.
  function automatic logic [7:0] model_read(input logic [7:0] a);
`ifdef CHIP_ID_EN
    if (a == 8'hD0) return 8'h60;
`endif
    if (a < 8'd16) return model_mem[a[3:0]];
    return 8'hFF;
  endfunction

  // A host write: always strobed, kept only inside the implemented range.
  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    if (a < 8'd16) model_mem[a[3:0]] = d;
  endtask

  // Every strobe cycle must match the oldest outstanding host write.
  always @(negedge clk) begin
    if (rst && wr_strobe) begin
      if (exp_q.size() == 0) checkOutput("unexpected_strobe_queue", exp_q.size(), 1);
      else checkOutput("strobe_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic pulled);
    pulled = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_q(); sda_m = b[7-i];
      wait_q(); scl_m = 1'b1;
      wait_q(); if (!sda_in) pulled = 1'b1;
      wait_q(); scl_m = 1'b0;
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_q(); sda_m = 1'b1;
      wait_q(); scl_m = 1'b1;
      wait_q(); b = {b[6:0], sda_bus};
      wait_q(); scl_m = 1'b0;
    end
  endtask

  task automatic ack_bit(input logic master_val, output logic bus_val);
    wait_q(); sda_m = master_val;
    wait_q(); scl_m = 1'b1;
    wait_q(); bus_val = sda_bus;
    wait_q(); scl_m = 1'b0;
  endtask

  // Send one byte from the master and expect the target to acknowledge it.
  task automatic send_acked(input string name, input logic [7:0] b);
    logic pulled, a;
    send_bits(b, 8, pulled);
    checkOutput({name, "_released"}, pulled, 0);
    ack_bit(1'b1, a);
    checkOutput({name, "_ack"}, a, 0);
  endtask

  // Full write transaction: address, pointer, then every byte of data_q.
  task automatic write_txn(input logic [6:0] dev, input logic [7:0] ptr);
    logic pulled, a;
    bus_start();
    send_bits({dev, 1'b0}, 8, pulled);
    checkOutput("addr_w_released", pulled, 0);
    ack_bit(1'b1, a);
    if (dev != TARGET) begin
      checkOutput("wrong_addr_nack", a, 1);
      checkOutput("wrong_addr_busy", busy, 0);
      bus_stop();
      return;
    end
    checkOutput("addr_w_ack", a, 0);
    checkOutput("busy_after_match", busy, 1);
    send_acked("ptr", ptr);
    model_ptr = ptr;
    foreach (data_q[i]) begin
      model_write(model_ptr, data_q[i]);
      model_ptr = model_ptr + 8'd1;
      send_acked("wdata", data_q[i]);
    end
    bus_stop();
    checkOutput("busy_after_stop", busy, 0);
  endtask

  // Optional pointer set, repeated START, read n bytes, NACK the last one.
  task automatic read_txn(input logic [7:0] ptr, input int n, input logic set_ptr);
    logic       a;
    logic [7:0] b;
    rx_q.delete();
    bus_start();
    if (set_ptr) begin
      send_acked("addr_w", {TARGET, 1'b0});
      send_acked("ptr", ptr);
      model_ptr = ptr;
      bus_start();
    end
    send_acked("addr_r", {TARGET, 1'b1});
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      rx_q.push_back(b);
      checkOutput("read_data", b, model_read(model_ptr));
      model_ptr = model_ptr + 8'd1;
      ack_bit(i == n - 1, a);
      checkOutput("master_ack_level", a, (i == n - 1) ? 1 : 0);
    end
    checkOutput("sda_after_nack", sda_in, 1);
    checkOutput("busy_after_nack", busy, 0);
    bus_stop();
  endtask

  // Randomised mix of writes, reads and foreign-address traffic.
  task automatic applyStimulus(input int count);
    int         op, n;
    logic [7:0] p;
    for (int k = 0; k < count; k++) begin
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      p  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
      case (op)
        0:       write_txn(TARGET, p);
        1:       read_txn(p, n, 1'b1);
        2:       read_txn(p, n, 1'b0);
        default: write_txn(TARGET ^ 7'(1 << $urandom_range(0, 6)), p);
      endcase
    end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic pulled, a;
    logic [7:0] chip_exp;
    rst   = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_sda_in", sda_in, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_strobe", wr_strobe, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] write A5,5A at 0x03");
    data_q = '{8'hA5, 8'h5A};
    write_txn(TARGET, 8'h03);

    $display("[TB] pointer 0x03 then read two bytes");
    read_txn(8'h03, 2, 1'b1);
    checkOutput("lit_read_03", rx_q[0], 8'hA5);
    checkOutput("lit_read_04", rx_q[1], 8'h5A);

    $display("[TB] foreign address 0x77");
    data_q = '{8'h33};
    write_txn(7'h77, 8'h01);

    $display("[TB] pointer wrap from 0xFF");
    data_q = '{8'h11, 8'h22};
    write_txn(TARGET, 8'hFF);
    read_txn(8'h0F, 2, 1'b1);
    checkOutput("lit_read_10", rx_q[1], 8'hFF);
    read_txn(8'h00, 1, 1'b1);
    checkOutput("lit_read_00", rx_q[0], 8'h22);

    $display("[TB] chip id register");
`ifdef CHIP_ID_EN
    chip_exp = 8'h60;
`else
    chip_exp = 8'hFF;
`endif
    read_txn(8'hD0, 1, 1'b1);
    checkOutput("lit_chip_id", rx_q[0], chip_exp);
    data_q = '{8'h00};
    write_txn(TARGET, 8'hD0);
    read_txn(8'hD0, 1, 1'b1);
    checkOutput("lit_chip_id_after_write", rx_q[0], chip_exp);

    $display("[TB] STOP in the middle of a data byte");
    bus_start();
    send_acked("addr_w", {TARGET, 1'b0});
    send_acked("ptr", 8'h05);
    model_ptr = 8'h05;
    send_bits(8'hC3, 4, pulled);
    bus_stop();
    checkOutput("busy_after_partial", busy, 0);
    read_txn(8'h05, 1, 1'b0);

    $display("[TB] random traffic");
    applyStimulus(24);

    $display("[TB] reset during address acknowledge");
    bus_start();
    send_bits({TARGET, 1'b0}, 8, pulled);
    wait_q();
    checkOutput("ack_driven_before_reset", sda_in, 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_sda_in", sda_in, 1);
    checkOutput("reset_mid_busy", busy, 0);
    checkOutput("reset_mid_wr_strobe", wr_strobe, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    exp_q.delete();
    repeat (4) @(negedge clk);
    read_txn(8'h00, 2, 1'b0);
    checkOutput("lit_after_reset_0", rx_q[0], 8'h00);
    data_q = '{8'h9C};
    write_txn(TARGET, 8'h07);
    read_txn(8'h06, 2, 1'b1);
    checkOutput("lit_after_reset_7", rx_q[1], 8'h9C);
    a = busy;
    checkOutput("final_busy", a, 0);

    repeat (10) @(negedge clk);
    checkOutput("strobe_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
